noc_packet_injector: RTL and testbench
======================================

Name: noc_packet_injector

Overview:
- PE-side transmitter that builds packets and injects them as 32-bit flits into a switch input port.
- Every flit carries the destination address in [31:24], so each switch routes every flit on its own.
- Takes one command (destination, length) and then a stream of 24-bit payload words from the PE.
- Emits one header flit followed by length payload flits on an AXI-stream-style valid/ready port.

Parameters:
- DataWidth, 32, network flit width; fixed at 32, other values unsupported.
- MyAddr, 0, this PE's node address, placed in header [23:16].
- MaxAddr, 15, highest legal destination address; commands with larger destinations are rejected.
- MaxLen, 255, highest legal payload length in flits; must be ≤255.

Ports:
- i_clk  input  1  single clock for all logic.
- i_reset  input  1  synchronous, active-high reset.
- i_cmd_valid  input  1  command valid.
- o_cmd_ready  output  1  command accepted when high with i_cmd_valid.
- i_cmd_dest  input  8  destination node address.
- i_cmd_len  input  8  payload flit count, 0..MaxLen.
- i_pe_data  input  24  payload word.
- i_pe_valid  input  1  payload valid.
- o_pe_ready  output  1  payload accepted when high with i_pe_valid.
- o_data  output  32  flit to switch input.
- o_data_valid  output  1  flit valid.
- i_data_ready  input  1  switch input ready.
- o_busy  output  1  high whenever state is not IDLE or o_data_valid is high.
- o_err  output  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; o_data_valid=0, o_data=0, o_err=0, seq=0, remaining=0.
  - o_cmd_ready and o_pe_ready forced 0 while i_reset is high.
- Output register: single stage, written only when it is free (free = ~o_data_valid | i_data_ready).
  - While o_data_valid=1 and i_data_ready=0, o_data holds stable.
  - Sustains 1 flit/cycle under continuous ready.
- States: IDLE, PAY.
- IDLE:
  - o_cmd_ready = free. o_pe_ready=0.
  - Command handshake with i_cmd_dest>MaxAddr or i_cmd_len>MaxLen:
    - o_err=1 for the next cycle only; no flit sent; seq unchanged; stay IDLE.
  - Legal command handshake:
    - Load header into the output register: [31:24]=dest, [23:16]=MyAddr, [15:8]=seq, [7:0]=len.
    - seq increments by 1 (8-bit, 255 wraps to 0).
    - Latch dest; remaining=len.
    - Next state is PAY if len≠0, otherwise IDLE (header-only packet).
  - Latency: header is valid on o_data the cycle after the command handshake.
- PAY:
  - o_cmd_ready=0. o_pe_ready = free.
  - On PE handshake: load flit {dest, i_pe_data} into the output register and decrement remaining.
  - When the handshaked word is the last one (remaining==1), next state is IDLE.
  - Latency: each payload word appears on o_data one cycle after its handshake.
- Back-to-back packets: a new command can be accepted the cycle after the last payload handshake, giving zero bubble when ready is held high.
- dest==MyAddr is legal and is sent normally (loopback is handled by the network).
- PE may drop i_pe_valid mid-packet: the injector waits indefinitely, with no timeout.
- Reset mid-packet:
  - The packet is abandoned and o_data_valid drops immediately.
  - This is permitted only because the downstream buffer shares the same reset.

Optional Feature:
- Macro NOC_TX_STATS_EN.
- When defined:
  - Adds output o_pkt_count (16 bits): count of headers accepted by the switch (header flit handshake), saturating at 0xFFFF.
  - Adds output o_err_count (8 bits): count of rejected commands, saturating at 0xFF.
  - Both counters clear on i_reset.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then cmd dest=3 len=2, PE words 0xABCDEF and 0x123456, i_data_ready=1:
  - Flits are 0x03000002 (MyAddr=0, seq=0), 0x03ABCDEF, 0x03123456 on consecutive cycles.
  - Afterwards o_busy=0.
- Cmd dest=16 (MaxAddr=15):
  - o_err pulses exactly 1 cycle and no o_data_valid follows.
  - A following legal cmd still uses seq=0.
- Cmd len=0 dest=5:
  - Single flit 0x05000000 is sent and the block returns to IDLE.
  - The next command header shows seq=1.
- i_data_ready held low 5 cycles during payload flit 1:
  - o_data stays stable; o_pe_ready=0 throughout.
  - No loss or duplication after ready returns.
- 256 header-only packets sent: seq field goes 0..255 then 0.
- Assert i_reset mid-PAY:
  - Next cycle o_data_valid=0 and state is IDLE.
  - A new cmd then produces a header with seq=0.
  - With NOC_TX_STATS_EN defined, o_pkt_count reads 0 after the reset.

Source files
------------

// File: rtl/noc_packet_injector_if.sv
// Bundles the command, PE payload and flit-stream signals of noc_packet_injector.
// The "master" modport is the injector side (it masters the flit stream);
// the "slave" modport is the surrounding PE/switch environment.
// Optional macro NOC_TX_STATS_EN adds the packet and error counter outputs.
interface noc_packet_injector_if;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [7:0]  i_cmd_dest;
    logic [7:0]  i_cmd_len;
    logic [23:0] i_pe_data;
    logic        i_pe_valid;
    logic        o_pe_ready;
    logic [31:0] o_data;
    logic        o_data_valid;
    logic        i_data_ready;
    logic        o_busy;
    logic        o_err;
`ifdef NOC_TX_STATS_EN
    logic [15:0] o_pkt_count;
    logic [7:0]  o_err_count;
`endif

    modport master (
        input  i_cmd_valid,
        output o_cmd_ready,
        input  i_cmd_dest,
        input  i_cmd_len,
        input  i_pe_data,
        input  i_pe_valid,
        output o_pe_ready,
        output o_data,
        output o_data_valid,
        input  i_data_ready,
        output o_busy,
`ifdef NOC_TX_STATS_EN
        output o_pkt_count,
        output o_err_count,
`endif
        output o_err
    );

    modport slave (
        output i_cmd_valid,
        input  o_cmd_ready,
        output i_cmd_dest,
        output i_cmd_len,
        output i_pe_data,
        output i_pe_valid,
        input  o_pe_ready,
        input  o_data,
        input  o_data_valid,
        output i_data_ready,
        input  o_busy,
`ifdef NOC_TX_STATS_EN
        input  o_pkt_count,
        input  o_err_count,
`endif
        input  o_err
    );
endinterface

// File: rtl/noc_packet_injector.sv
// PE-side packet injector: accepts a (dest, len) command, emits a header flit
// {dest, MyAddr, seq, len} followed by len payload flits {dest, pe_word}
// through a single-stage valid/ready output register.
// Optional macro NOC_TX_STATS_EN adds saturating packet/error counters.
module noc_packet_injector #(
    parameter int DataWidth = 32,
    parameter int MyAddr    = 0,
    parameter int MaxAddr   = 15,
    parameter int MaxLen    = 255
) (
    input logic                  i_clk,
    input logic                  i_reset,
    noc_packet_injector_if.master bus
);

    localparam logic [7:0] MY_ADDR  = 8'(MyAddr);
    localparam logic [7:0] MAX_ADDR = 8'(MaxAddr);
    localparam logic [7:0] MAX_LEN  = 8'(MaxLen);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PAY  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [DataWidth-1:0] data_q;
    logic                 data_valid_q;
    logic                 err_q;
    logic [7:0]           seq_q;
    logic [7:0]           dest_q;
    logic [7:0]           remaining_q;

    logic                 free;
    logic                 cmd_ready;
    logic                 pe_ready;
    logic                 cmd_fire;
    logic                 cmd_bad;
    logic                 cmd_ok;
    logic                 pe_fire;
    logic                 last_word;

    // Output register can take a new flit when empty or being drained this cycle.
    assign free      = ~data_valid_q | bus.i_data_ready;

    assign cmd_fire  = bus.i_cmd_valid & cmd_ready;
    assign cmd_bad   = (bus.i_cmd_dest > MAX_ADDR) | (bus.i_cmd_len > MAX_LEN);
    assign cmd_ok    = cmd_fire & ~cmd_bad;
    assign pe_fire   = bus.i_pe_valid & pe_ready;
    assign last_word = pe_fire & (remaining_q == 8'd1);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: header-only packets never leave IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (cmd_ok && (bus.i_cmd_len != 8'd0)) begin
                    state_next = PAY;
                end
            end
            PAY: begin
                if (last_word) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake readies; both are held low during reset.
    always_comb begin
        cmd_ready = 1'b0;
        pe_ready  = 1'b0;
        if (!i_reset) begin
            unique case (state)
                IDLE:    cmd_ready = free;
                PAY:     pe_ready  = free;
                default: begin
                    cmd_ready = 1'b0;
                    pe_ready  = 1'b0;
                end
            endcase
        end
    end

    // Output flit register: load header or payload, otherwise drain on ready.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else if (cmd_ok) begin
            data_q       <= {bus.i_cmd_dest, MY_ADDR, seq_q, bus.i_cmd_len};
            data_valid_q <= 1'b1;
        end else if (pe_fire) begin
            data_q       <= {dest_q, bus.i_pe_data};
            data_valid_q <= 1'b1;
        end else if (bus.i_data_ready) begin
            data_valid_q <= 1'b0;
        end
    end

    // Packet context: sequence number, latched destination, words left.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            seq_q       <= '0;
            dest_q      <= '0;
            remaining_q <= '0;
        end else if (cmd_ok) begin
            seq_q       <= seq_q + 8'd1;
            dest_q      <= bus.i_cmd_dest;
            remaining_q <= bus.i_cmd_len;
        end else if (pe_fire) begin
            remaining_q <= remaining_q - 8'd1;
        end
    end

    // Single-cycle error pulse for a rejected command.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= cmd_fire & cmd_bad;
        end
    end

    assign bus.o_cmd_ready  = cmd_ready;
    assign bus.o_pe_ready   = pe_ready;
    assign bus.o_data       = data_q;
    assign bus.o_data_valid = data_valid_q;
    assign bus.o_err        = err_q;
    assign bus.o_busy       = (state != IDLE) | data_valid_q;

`ifdef NOC_TX_STATS_EN
    logic        hdr_q;
    logic [15:0] pkt_count_q;
    logic [7:0]  err_count_q;

    // Tracks whether the flit in the output register is a header, so the
    // packet count advances on the header's downstream handshake.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hdr_q <= 1'b0;
        end else if (cmd_ok) begin
            hdr_q <= 1'b1;
        end else if (pe_fire) begin
            hdr_q <= 1'b0;
        end
    end

    // Saturating counters for accepted headers and rejected commands.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            if (data_valid_q && bus.i_data_ready && hdr_q && (pkt_count_q != '1)) begin
                pkt_count_q <= pkt_count_q + 16'd1;
            end
            if (cmd_fire && cmd_bad && (err_count_q != '1)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign bus.o_pkt_count = pkt_count_q;
    assign bus.o_err_count = err_count_q;
`endif

endmodule

// File: tb/tb_noc_packet_injector.sv
// Self-checking bench for noc_packet_injector: directed scenarios plus a
// randomized phase, checked against a flit-queue reference model.
// Define NOC_TX_STATS_EN to also check the statistics counters.
module tb_noc_packet_injector;

    localparam int MY_ADDR  = 0;
    localparam int MAX_ADDR = 15;
    localparam int MAX_LEN  = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    noc_packet_injector_if ifc ();

    noc_packet_injector #(
        .DataWidth (32),
        .MyAddr    (MY_ADDR),
        .MaxAddr   (MAX_ADDR),
        .MaxLen    (MAX_LEN)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (ifc)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          bp       = 1'b0;
    logic [31:0] got_q[$];
    int          got_cyc[$];
    logic [31:0] exp_q[$];
    logic [7:0]  m_seq    = 8'd0;
    int          m_pkts   = 0;
    int          m_errs   = 0;

    // Capture every flit the switch accepts.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && ifc.o_data_valid && ifc.i_data_ready) begin
            got_q.push_back(ifc.o_data);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp) ifc.i_data_ready = ($urandom_range(0, 3) != 0);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] d, input logic [7:0] l);
        int n = 0;
        #1;
        ifc.i_cmd_valid = 1'b1;
        ifc.i_cmd_dest  = d;
        ifc.i_cmd_len   = l;
        while (!ifc.o_cmd_ready && n < 200) begin
            tick();
            n++;
        end
        chk("cmd_accept_timeout", 32'(n < 200), 32'd1);
        tick();
        ifc.i_cmd_valid = 1'b0;
        if (int'(d) > MAX_ADDR || int'(l) > MAX_LEN) begin
            m_errs++;
        end else begin
            exp_q.push_back({d, 8'(MY_ADDR), m_seq, l});
            m_seq = m_seq + 8'd1;
            m_pkts++;
        end
    endtask

    task automatic send_word(input logic [23:0] w, input logic [7:0] d);
        int n = 0;
        if (bp) repeat ($urandom_range(0, 2)) tick();
        #1;
        ifc.i_pe_valid = 1'b1;
        ifc.i_pe_data  = w;
        while (!ifc.o_pe_ready && n < 200) begin
            tick();
            n++;
        end
        chk("pe_accept_timeout", 32'(n < 200), 32'd1);
        tick();
        ifc.i_pe_valid = 1'b0;
        exp_q.push_back({d, w});
    endtask

    task automatic drain();
        int n = 0;
        while (ifc.o_busy && n < 300) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 300), 32'd1);
    endtask

    task automatic compare(input string tag);
        int m;
        chk($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_flit%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0]  d;
        logic [7:0]  l;
        logic [23:0] w1;
        logic [7:0]  seq_before;

        ifc.i_cmd_valid  = 1'b1;
        ifc.i_cmd_dest   = 8'd3;
        ifc.i_cmd_len    = 8'd1;
        ifc.i_pe_data    = '0;
        ifc.i_pe_valid   = 1'b1;
        ifc.i_data_ready = 1'b1;

        // Reset state; readies must stay low even with valid requests.
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(ifc.o_cmd_ready), 32'd0);
        chk("rst_pe_ready", 32'(ifc.o_pe_ready), 32'd0);
        chk("rst_data_valid", 32'(ifc.o_data_valid), 32'd0);
        chk("rst_data", ifc.o_data, 32'd0);
        chk("rst_err", 32'(ifc.o_err), 32'd0);
        chk("rst_busy", 32'(ifc.o_busy), 32'd0);
        ifc.i_cmd_valid = 1'b0;
        ifc.i_pe_valid  = 1'b0;
        rst = 1'b0;
        tick();

        // Basic packet: header the cycle after the command, then two payload flits.
        send_cmd(8'd3, 8'd2);
        chk("t1_hdr_valid", 32'(ifc.o_data_valid), 32'd1);
        chk("t1_hdr_data", ifc.o_data, 32'h0300_0002);
        send_word(24'hABCDEF, 8'd3);
        send_word(24'h123456, 8'd3);
        drain();
        chk("t1_busy_after", 32'(ifc.o_busy), 32'd0);
        chk("t1_gap01", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
        chk("t1_gap12", 32'(got_cyc[2] - got_cyc[1]), 32'd1);
        chk("t1_w1_literal", got_q[1], 32'h03AB_CDEF);
        chk("t1_w2_literal", got_q[2], 32'h0312_3456);
        compare("t1");

        // Illegal destination: single-cycle error, no flit, sequence unchanged.
        send_cmd(8'd16, 8'd1);
        chk("t2_err_pulse", 32'(ifc.o_err), 32'd1);
        chk("t2_no_flit", 32'(ifc.o_data_valid), 32'd0);
        tick();
        chk("t2_err_clear", 32'(ifc.o_err), 32'd0);
        repeat (3) begin
            tick();
            chk("t2_still_no_flit", 32'(ifc.o_data_valid), 32'd0);
        end
        send_cmd(8'd1, 8'd0);
        chk("t2_seq_unchanged", ifc.o_data, 32'h0100_0100);
        drain();
        // Illegal length, then boundary-legal destinations and lengths.
        send_cmd(8'd2, 8'(MAX_LEN + 1));
        chk("t2_len_err", 32'(ifc.o_err), 32'd1);
        send_cmd(8'(MAX_ADDR), 8'd1);
        send_word(24'h00F00D, 8'(MAX_ADDR));
        send_cmd(8'(MY_ADDR), 8'd1);
        send_word(24'h10_0B0C, 8'(MY_ADDR));
        send_cmd(8'd4, 8'(MAX_LEN));
        for (int i = 0; i < MAX_LEN; i++) send_word(24'(i * 3 + 7), 8'd4);
        drain();
        compare("t2");

        // Header-only packet, followed by a header carrying the next sequence number.
        seq_before = m_seq;
        send_cmd(8'd5, 8'd0);
        chk("t3_hdr_only", ifc.o_data, {8'd5, 8'(MY_ADDR), seq_before, 8'd0});
        drain();
        chk("t3_idle", 32'(ifc.o_busy), 32'd0);
        send_cmd(8'd6, 8'd0);
        chk("t3_next_seq", 32'(ifc.o_data[15:8]), 32'(seq_before + 8'd1));
        drain();
        compare("t3");

        // Downstream stall for five cycles while payload flit 1 is held.
        send_cmd(8'd7, 8'd3);
        w1 = 24'h5A5A01;
        send_word(w1, 8'd7);
        ifc.i_data_ready = 1'b0;
        ifc.i_pe_valid   = 1'b1;
        ifc.i_pe_data    = 24'h5A5A02;
        #1;
        repeat (5) begin
            chk("t4_hold_data", ifc.o_data, {8'd7, w1});
            chk("t4_hold_valid", 32'(ifc.o_data_valid), 32'd1);
            chk("t4_pe_blocked", 32'(ifc.o_pe_ready), 32'd0);
            tick();
        end
        ifc.i_data_ready = 1'b1;
        send_word(24'h5A5A02, 8'd7);
        send_word(24'h5A5A03, 8'd7);
        drain();
        compare("t4");

        // 256 header-only packets: the sequence field runs a full cycle and wraps.
        seq_before = m_seq;
        for (int i = 0; i < 256; i++) send_cmd(8'(i % 16), 8'd0);
        send_cmd(8'd9, 8'd0);
        chk("t5_wrap", 32'(ifc.o_data[15:8]), 32'(seq_before));
        drain();
        compare("t5");

        // Randomized traffic with random backpressure and PE gaps.
        bp = 1'b1;
        for (int p = 0; p < 40; p++) begin
            d = 8'($urandom_range(0, 18));
            l = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(MAX_LEN + 1, 255))
                                            : 8'($urandom_range(0, 9));
            send_cmd(d, l);
            if (int'(d) > MAX_ADDR || int'(l) > MAX_LEN) begin
                chk("t6_err", 32'(ifc.o_err), 32'd1);
            end else begin
                for (int k = 0; k < int'(l); k++) send_word(24'($urandom), d);
            end
        end
        bp = 1'b0;
        ifc.i_data_ready = 1'b1;
        drain();
        compare("t6");
`ifdef NOC_TX_STATS_EN
        chk("stats_pkt_count", 32'(ifc.o_pkt_count), 32'(m_pkts));
        chk("stats_err_count", 32'(ifc.o_err_count), 32'(m_errs));
`endif

        // Reset in the middle of a payload: packet abandoned, sequence restarts.
        send_cmd(8'd2, 8'd4);
        send_word(24'h777777, 8'd2);
        rst = 1'b1;
        tick();
        chk("t7_valid_dropped", 32'(ifc.o_data_valid), 32'd0);
        chk("t7_idle", 32'(ifc.o_busy), 32'd0);
        rst = 1'b0;
        m_seq  = 8'd0;
        m_pkts = 0;
        m_errs = 0;
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
`ifdef NOC_TX_STATS_EN
        chk("t7_pkt_count_cleared", 32'(ifc.o_pkt_count), 32'd0);
        chk("t7_err_count_cleared", 32'(ifc.o_err_count), 32'd0);
`endif
        tick();
        send_cmd(8'd9, 8'd1);
        chk("t7_seq_restart", ifc.o_data, 32'h0900_0001);
        send_word(24'h0C0FFE, 8'd9);
        drain();
        compare("t7");
`ifdef NOC_TX_STATS_EN
        chk("t7_pkt_count", 32'(ifc.o_pkt_count), 32'(m_pkts));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
